// File: rtl/boot_fetch.sv
// Instruction fetch stage for the byte-wide boot ROM: issues byte addresses, absorbs the
// one-cycle ROM latency and assembles little-endian instruction words for decode.
module boot_fetch #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int INSTR_BYTES = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic [ADDR_WIDTH-1:0]             rom_addr,
   input  logic [DATA_WIDTH-1:0]             rom_data,
   output logic [DATA_WIDTH*INSTR_BYTES-1:0] instr,
   output logic [ADDR_WIDTH-1:0]             instr_pc,
   output logic                              instr_valid,
   input  logic                              instr_ready,
   input  logic                              redirect_valid,
   input  logic [ADDR_WIDTH-1:0]             redirect_pc
);

   localparam int OFS_W = $clog2(INSTR_BYTES);
   localparam int CNT_W = OFS_W + 1;

   typedef enum logic {
      S_FETCH,
      S_HOLD
   } state_t;

   state_t                            r_state;
   logic [CNT_W-1:0]                  r_k;
   logic [ADDR_WIDTH-1:0]             r_base;
   logic [ADDR_WIDTH-1:0]             r_rom_addr;
   logic [ADDR_WIDTH-1:0]             r_instr_pc;
   logic [DATA_WIDTH*INSTR_BYTES-1:0] r_instr;
   logic                              r_valid;

   logic [ADDR_WIDTH-1:0] w_redirect_base;
   logic [ADDR_WIDTH-1:0] w_next_base;
   logic [OFS_W-1:0]      w_byte_idx;
   logic                  w_last;
   logic                  w_accept;
   logic                  w_unused_ofs;

   // Redirect targets are always word aligned; the dropped offset bits are intentionally unused.
   assign w_redirect_base = {redirect_pc[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
   assign w_unused_ofs    = ^redirect_pc[OFS_W-1:0];
   assign w_next_base     = r_base + ADDR_WIDTH'(INSTR_BYTES);
   assign w_byte_idx      = r_k[OFS_W-1:0] - OFS_W'(1);
   assign w_last          = (r_k == CNT_W'(INSTR_BYTES));
   assign w_accept        = r_valid && instr_ready;

   // During cycle k the ROM returns the byte issued in cycle k-1, so byte k-1 lands at the end
   // of cycle k; rom_addr already points at the next word's base by the time HOLD is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_k        <= '0;
         r_base     <= RESET_PC;
         r_rom_addr <= RESET_PC;
         r_instr_pc <= RESET_PC;
         r_instr    <= '0;
         r_valid    <= 1'b0;
      end else if (redirect_valid) begin
         r_state    <= S_FETCH;
         r_k        <= '0;
         r_base     <= w_redirect_base;
         r_rom_addr <= w_redirect_base;
         r_valid    <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               for (int i = 0; i < INSTR_BYTES; i++) begin
                  if ((r_k != '0) && (w_byte_idx == OFS_W'(i))) begin
                     r_instr[i*DATA_WIDTH +: DATA_WIDTH] <= rom_data;
                  end
               end
               if (w_last) begin
                  r_instr_pc <= r_base;
                  r_valid    <= 1'b1;
                  r_state    <= S_HOLD;
               end else begin
                  r_k        <= r_k + CNT_W'(1);
                  r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
               end
            end
            S_HOLD: begin
               if (w_accept) begin
                  r_valid <= 1'b0;
                  r_base  <= w_next_base;
                  r_k     <= '0;
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_FETCH;
               r_k     <= '0;
            end
         endcase
      end
   end

   assign rom_addr    = r_rom_addr;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;

endmodule

// File: tb/tb_boot_fetch.sv
// Self-checking bench for boot_fetch: a behavioural ROM plus a word-level reference model
// that predicts which PC is presented next and what word lives there.
module tb_boot_fetch;

   logic        clk;
   logic        rst;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;

   logic [7:0]  mem [256];
   int          nCompared;
   int          nMismatched;

   boot_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data reflects the address presented in the previous cycle.
   always @(posedge clk) rom_data <= mem[rom_addr];

   // The word at pc is simply four consecutive ROM bytes, lowest address in the low byte.
   function automatic logic [31:0] word_at(input logic [7:0] pc);
      logic [31:0] w;
      for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[pc + 8'(b)];
      return w;
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts cycles until a word is presented; a missing word counts as a failure.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!instr_valid && cyc < 40) begin
         step();
         cyc++;
      end
      if (!instr_valid) begin
         nCompared++; nMismatched++;
         $display("[TB] FAIL wait_valid: no word after %0d cycles", cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      nCompared += 4;
      if (rom_addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_addr got %h want 00", rom_addr); end
      if (instr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_instr got %h want 0", instr); end
      if (instr_pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_pc got %h want 00", instr_pc); end
      if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %b want 0", instr_valid); end
   endtask

   task automatic test_sequential();
      int cyc;
      logic [7:0] init [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      for (int i = 0; i < 8; i++) mem[i] = init[i];
      instr_ready = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();
      nCompared++;
      if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL seq_early got %b want 0", instr_valid); end
      step();
      nCompared += 3;
      if (instr_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_valid0 got %b want 1", instr_valid); end
      if (instr !== 32'h00000013) begin nMismatched++; $display("[TB] FAIL seq_instr0 got %h want 00000013", instr); end
      if (instr_pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL seq_pc0 got %h want 00", instr_pc); end
      step();
      wait_valid(cyc);
      nCompared += 3;
      if (cyc != 5) begin nMismatched++; $display("[TB] FAIL seq_latency got %0d want 5", cyc); end
      if (instr !== 32'h00100093) begin nMismatched++; $display("[TB] FAIL seq_instr1 got %h want 00100093", instr); end
      if (instr_pc !== 8'h04) begin nMismatched++; $display("[TB] FAIL seq_pc1 got %h want 04", instr_pc); end
      instr_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [31:0] w;
      apply_reset();
      wait_valid(cyc);
      w = word_at(8'h00);
      for (int i = 0; i < 10; i++) begin
         step();
         nCompared++;
         if (instr !== w || instr_pc !== 8'h00 || instr_valid !== 1'b1 || rom_addr !== 8'h04) begin
            nMismatched++;
            $display("[TB] FAIL bp_hold got instr=%h pc=%h v=%b addr=%h want %h/00/1/04",
                     instr, instr_pc, instr_valid, rom_addr, w);
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      nCompared++;
      if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_drop got %b want 0", instr_valid); end
      wait_valid(cyc);
      nCompared += 2;
      if (cyc != 5) begin nMismatched++; $display("[TB] FAIL bp_latency got %0d want 5", cyc); end
      if (instr_pc !== 8'h04) begin nMismatched++; $display("[TB] FAIL bp_pc got %h want 04", instr_pc); end
      for (int i = 0; i < 3; i++) step();
      nCompared++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h04) begin
         nMismatched++; $display("[TB] FAIL bp_single got v=%b pc=%h want 1/04", instr_valid, instr_pc);
      end
   endtask

   task automatic test_redirect();
      int cyc;
      apply_reset();
      step();
      step();
      nCompared++;
      if (rom_addr !== 8'h02) begin nMismatched++; $display("[TB] FAIL rd_k2_addr got %h want 02", rom_addr); end
      redirect_valid = 1'b1;
      redirect_pc    = 8'h43;
      step();
      redirect_valid = 1'b0;
      nCompared += 2;
      if (rom_addr !== 8'h40) begin nMismatched++; $display("[TB] FAIL rd_addr got %h want 40", rom_addr); end
      if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_valid got %b want 0", instr_valid); end
      wait_valid(cyc);
      nCompared += 3;
      if (cyc != 5) begin nMismatched++; $display("[TB] FAIL rd_latency got %0d want 5", cyc); end
      if (instr_pc !== 8'h40) begin nMismatched++; $display("[TB] FAIL rd_pc got %h want 40", instr_pc); end
      if (instr !== word_at(8'h40)) begin nMismatched++; $display("[TB] FAIL rd_instr got %h want %h", instr, word_at(8'h40)); end
   endtask

   task automatic test_wrap();
      int cyc;
      mem[8'hFC] = 8'h11; mem[8'hFD] = 8'h22; mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h44;
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFC;
      step();
      redirect_valid = 1'b0;
      wait_valid(cyc);
      nCompared += 2;
      if (instr !== 32'h44332211) begin nMismatched++; $display("[TB] FAIL wrap_instr got %h want 44332211", instr); end
      if (instr_pc !== 8'hFC) begin nMismatched++; $display("[TB] FAIL wrap_pc got %h want fc", instr_pc); end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      wait_valid(cyc);
      nCompared += 2;
      if (instr_pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL wrap_next_pc got %h want 00", instr_pc); end
      if (instr !== word_at(8'h00)) begin nMismatched++; $display("[TB] FAIL wrap_next_instr got %h want %h", instr, word_at(8'h00)); end
   endtask

   task automatic test_accept_redirect();
      int cyc;
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h20;
      step();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      wait_valid(cyc);
      nCompared += 2;
      if (instr_pc !== 8'h20) begin nMismatched++; $display("[TB] FAIL ar_pc got %h want 20", instr_pc); end
      if (instr !== word_at(8'h20)) begin nMismatched++; $display("[TB] FAIL ar_instr got %h want %h", instr, word_at(8'h20)); end
   endtask

   task automatic test_async_reset();
      int cyc;
      apply_reset();
      for (int i = 0; i < 3; i++) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      nCompared++;
      if (rom_addr !== 8'h00 || instr !== 32'h0 || instr_valid !== 1'b0 || instr_pc !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL async_rst got addr=%h instr=%h v=%b pc=%h want 00/0/0/00",
                  rom_addr, instr, instr_valid, instr_pc);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_valid(cyc);
      nCompared += 2;
      if (cyc != 5 || instr_pc !== 8'h00) begin
         nMismatched++; $display("[TB] FAIL async_restart got cyc=%0d pc=%h want 5/00", cyc, instr_pc);
      end
      if (instr !== word_at(8'h00)) begin nMismatched++; $display("[TB] FAIL async_instr got %h want %h", instr, word_at(8'h00)); end
   endtask

   // Random mix of stalls, accepts and redirects; the model just tracks the next expected PC.
   task automatic test_random();
      int cyc;
      int action;
      logic [7:0] expPc;
      logic [7:0] tgt;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      apply_reset();
      expPc = 8'h00;
      for (int it = 0; it < 40; it++) begin
         wait_valid(cyc);
         nCompared++;
         if (cyc != 5 || instr_pc !== expPc || instr !== word_at(expPc)) begin
            nMismatched++;
            $display("[TB] FAIL rand_word it=%0d got cyc=%0d pc=%h instr=%h want 5/%h/%h",
                     it, cyc, instr_pc, instr, expPc, word_at(expPc));
         end
         for (int h = 0; h < int'($urandom_range(0, 3)); h++) step();
         action = int'($urandom_range(0, 3));
         tgt    = 8'($urandom);
         instr_ready    = (action != 2);
         redirect_valid = (action >= 2);
         redirect_pc    = tgt;
         step();
         instr_ready    = 1'b0;
         redirect_valid = 1'b0;
         expPc = (action >= 2) ? (tgt & 8'hFC) : expPc + 8'd4;
      end
   endtask

   initial begin
      clk            = 1'b0;
      rst            = 1'b1;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      nCompared      = 0;
      nMismatched    = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_accept_redirect();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
